// File: rtl/fifo_drain_stage.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream as fixed bursts with idle gaps.
// Define DRAIN_WORD_COUNT_EN to add the word_count output (delivered-word counter).
module fifo_drain_stage #(
    parameter int WIDTH   = 16,
    parameter int BURST   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
`ifdef DRAIN_WORD_COUNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    localparam int IW = $clog2(BURST + 1);
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

    state_t                  state, state_next;
    logic [IW-1:0]           issued;
    logic [GW-1:0]           gap_cnt;
    logic                    inflight, inflight_last;
    logic [1:0]              occ;
    logic [1:0][WIDTH-1:0]   buf_data;
    logic [1:0]              buf_last;
    logic                    pop, tag_last;
    logic [2:0]              occ_sum, occ_lim;

    assign pop      = m_valid & m_ready;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = buf_data[0];
    assign m_last   = m_valid & buf_last[0];
    assign tag_last = (issued == IW'(BURST - 1));
    // Room check counts the word still on fifo_rd_data and credits a same-cycle drain.
    assign occ_sum  = {1'b0, occ} + {2'b00, inflight};
    assign occ_lim  = 3'd2 + {2'b00, pop};

    always_comb begin
        state_next = state;
        fifo_r_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_r_en  = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                fifo_r_en = !fifo_empty && (issued < IW'(BURST)) && (occ_sum < occ_lim);
                if (pop && m_last)
                    state_next = (GAP_LEN == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LEN - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        fifo_r_en = fifo_r_en & rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            issued        <= '0;
            gap_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            buf_data      <= '0;
            buf_last      <= '0;
        end else begin
            state         <= state_next;
            inflight      <= fifo_r_en;
            inflight_last <= fifo_r_en & tag_last;
            gap_cnt       <= (state == GAP) ? gap_cnt + GW'(1) : '0;

            if (state == READ && state_next != READ)
                issued <= '0;
            else if (fifo_r_en)
                issued <= issued + IW'(1);

            // Head is entry 0; a drain shifts entry 1 forward before any new word lands.
            if (pop) begin
                if (occ == 2'd2) begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    if (inflight) begin
                        buf_data[1] <= fifo_rd_data;
                        buf_last[1] <= inflight_last;
                    end
                end else if (inflight) begin
                    buf_data[0] <= fifo_rd_data;
                    buf_last[0] <= inflight_last;
                end
                occ <= occ - 2'd1 + {1'b0, inflight};
            end else if (inflight) begin
                if (occ == 2'd0) begin
                    buf_data[0] <= fifo_rd_data;
                    buf_last[0] <= inflight_last;
                end else begin
                    buf_data[1] <= fifo_rd_data;
                    buf_last[1] <= inflight_last;
                end
                occ <= occ + 2'd1;
            end
        end
    end

`ifdef DRAIN_WORD_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            word_count <= 16'd0;
        else if (pop)
            word_count <= word_count + 16'd1;
    end
`endif

endmodule
